// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int PC_W      = 30;
    localparam int IF_DATA_W = 62;

    // sll $0,$0,0 encodes as all zeroes, so a bubble is simply zero data.
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } if_state_e;

    // Word PC increment; wraps naturally at 30 bits.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: req/addr from the fetch stage, rdy/rdata from memory.
interface if_stage_if;

    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry holding buffer for a fetch that completes while decode is stalled.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [IF_DATA_W-1:0] din,
    output logic [IF_DATA_W-1:0] dout,
    output logic                 valid
);

    logic [IF_DATA_W-1:0] data_r;
    logic                 valid_r;

    // Load wins over clear; the fetch controller never asserts both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= {IF_DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= din;
            valid_r <= 1'b1;
        end else if (clear) begin
            data_r  <= {IF_DATA_W{1'b0}};
            valid_r <= 1'b0;
        end
    end

    assign dout  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: word PC, req/rdy imem fetch, IF/ID register with stall/flush/redirect.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_wait_cnt outputs.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 30'h0000_0C00,
    parameter logic [PC_W-1:0] EXC_PC   = 30'h0000_1060
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IF_STALL,
    input  logic                 IF_FLUSH,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic                 exc_valid,
    if_stage_if.master           imem,
    output logic [IF_DATA_W-1:0] o_ID_DATA,
    output logic                 o_ID_valid,
    output logic [PC_W-1:0]      o_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_wait_cnt
`endif
);

    localparam logic [IF_DATA_W-1:0] BUBBLE = {30'h0000_0000, NOP};

    if_state_e            state_r;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      pc_next_r;
    logic [IF_DATA_W-1:0] id_data_r;
    logic                 id_valid_r;

    logic [PC_W-1:0]      pc_inc_s;
    logic [PC_W-1:0]      target_s;
    logic                 req_s;
    logic                 xfer_s;
    logic                 redir_s;
    logic                 buf_load_s;
    logic                 buf_clear_s;
    logic [IF_DATA_W-1:0] buf_data_s;
    logic                 buf_valid_s;

    // Request is a decode of the state register, forced low while reset is held.
    assign req_s    = ~rst & ((state_r == FETCH) | (state_r == DROP));
    assign xfer_s   = req_s & imem.imem_rdy;
    assign redir_s  = exc_valid | redirect_valid;
    assign target_s = exc_valid ? EXC_PC : redirect_pc;
    assign pc_inc_s = pc_inc(pc_r);

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;
    assign o_ID_DATA      = id_data_r;
    assign o_ID_valid     = id_valid_r;
    assign o_pc           = pc_r;

    // Buffer control: redirects and flushes empty it, a stalled transfer fills it.
    always_comb begin
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        if (redir_s | IF_FLUSH) begin
            buf_clear_s = 1'b1;
        end else if ((state_r == FETCH) && xfer_s && IF_STALL) begin
            buf_load_s = 1'b1;
        end else if ((state_r == HOLD) && !IF_STALL) begin
            buf_clear_s = 1'b1;
        end else begin
            buf_load_s  = 1'b0;
            buf_clear_s = 1'b0;
        end
    end

    if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load_s),
        .clear (buf_clear_s),
        .din   ({pc_inc_s, imem.imem_rdata}),
        .dout  (buf_data_s),
        .valid (buf_valid_s)
    );

    // Fetch FSM with PC and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            pc_next_r  <= {PC_W{1'b0}};
            id_data_r  <= BUBBLE;
            id_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (redir_s) begin
                        id_data_r  <= BUBBLE;
                        id_valid_r <= 1'b0;
                        // An in-flight request must complete at its old address first.
                        if (xfer_s) begin
                            pc_r <= target_s;
                        end else begin
                            pc_next_r <= target_s;
                            state_r   <= DROP;
                        end
                    end else if (IF_FLUSH) begin
                        id_data_r  <= BUBBLE;
                        id_valid_r <= 1'b0;
                        if (xfer_s) begin
                            pc_r <= pc_inc_s;
                        end
                    end else if (xfer_s) begin
                        pc_r <= pc_inc_s;
                        if (IF_STALL) begin
                            state_r <= HOLD;
                        end else begin
                            id_data_r  <= {pc_inc_s, imem.imem_rdata};
                            id_valid_r <= 1'b1;
                        end
                    end else if (!IF_STALL) begin
                        id_data_r  <= BUBBLE;
                        id_valid_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redir_s) begin
                        id_data_r  <= BUBBLE;
                        id_valid_r <= 1'b0;
                        pc_r       <= target_s;
                        state_r    <= FETCH;
                    end else if (IF_FLUSH) begin
                        id_data_r  <= BUBBLE;
                        id_valid_r <= 1'b0;
                        state_r    <= FETCH;
                    end else if (!IF_STALL) begin
                        id_data_r  <= buf_data_s;
                        id_valid_r <= buf_valid_s;
                        state_r    <= FETCH;
                    end
                end
                DROP: begin
                    if (redir_s) begin
                        id_data_r  <= BUBBLE;
                        id_valid_r <= 1'b0;
                        if (xfer_s) begin
                            pc_r    <= target_s;
                            state_r <= FETCH;
                        end else begin
                            pc_next_r <= target_s;
                        end
                    end else begin
                        if (IF_FLUSH) begin
                            id_data_r  <= BUBBLE;
                            id_valid_r <= 1'b0;
                        end
                        if (xfer_s) begin
                            pc_r    <= pc_next_r;
                            state_r <= FETCH;
                        end
                    end
                end
                default: begin
                    state_r    <= FETCH;
                    id_data_r  <= BUBBLE;
                    id_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] wait_cnt_r;

    // Useful fetches exclude transfers squashed by a same-cycle redirect or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_r <= 32'd0;
            wait_cnt_r  <= 32'd0;
        end else begin
            if (xfer_s && (state_r == FETCH) && !redir_s && !IF_FLUSH) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (req_s && !imem.imem_rdy) begin
                wait_cnt_r <= wait_cnt_r + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_r;
    assign perf_wait_cnt  = wait_cnt_r;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        red = 1'b0;
    logic        exc = 1'b0;
    logic        rdy = 1'b0;
    logic [29:0] rpc = 30'h0;

    logic [61:0] id_data;
    logic        id_valid;
    logic [29:0] pc_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_wait;
`endif

    // Model: fetch pointer, pending redirect target, one held instruction, IF/ID contents.
    logic [29:0] m_pc;
    logic [29:0] m_tgt;
    logic        m_drop;
    logic        m_held_v;
    logic [61:0] m_held;
    logic [61:0] m_data;
    logic        m_valid;
    logic [31:0] m_fcnt;
    logic [31:0] m_wcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hA5C3_0F96;
    endfunction

    if_stage_if bus ();
    assign bus.imem_rdy   = rdy;
    assign bus.imem_rdata = mem_f(bus.imem_addr);

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .IF_STALL       (stall),
        .IF_FLUSH       (flush),
        .redirect_valid (red),
        .redirect_pc    (rpc),
        .exc_valid      (exc),
        .imem           (bus.master),
        .o_ID_DATA      (id_data),
        .o_ID_valid     (id_valid),
        .o_pc           (pc_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch),
        .perf_wait_cnt  (perf_wait)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 30'h0C00; m_tgt = 30'h0; m_drop = 1'b0; m_held_v = 1'b0;
        m_held = 62'h0; m_data = 62'h0; m_valid = 1'b0; m_fcnt = 32'd0; m_wcnt = 32'd0;
    endtask

    // Apply one cycle of inputs and advance the model to what the next edge must produce.
    task automatic drive_and_step(input bit e, input bit r, input logic [29:0] rp,
                                  input bit f, input bit s, input bit rd);
        bit req;
        bit xf;
        logic [29:0] t;
        exc = e; red = r; rpc = rp; flush = f; stall = s; rdy = rd;
        req = !m_held_v;
        xf  = req && rd;
        t   = e ? 30'h1060 : rp;
        if (req && !rd) m_wcnt = m_wcnt + 32'd1;
        if (xf && !m_drop && !(e || r) && !f) m_fcnt = m_fcnt + 32'd1;
        if (e || r) begin
            m_data = 62'h0; m_valid = 1'b0; m_held_v = 1'b0;
            if (xf) begin
                m_pc = t; m_drop = 1'b0;
            end else if (req) begin
                m_drop = 1'b1; m_tgt = t;
            end else begin
                m_pc = t;
            end
        end else if (m_drop) begin
            if (f) begin m_data = 62'h0; m_valid = 1'b0; end
            if (xf) begin m_pc = m_tgt; m_drop = 1'b0; end
        end else if (f) begin
            m_data = 62'h0; m_valid = 1'b0; m_held_v = 1'b0;
            if (xf) m_pc = m_pc + 30'd1;
        end else if (m_held_v) begin
            if (!s) begin m_data = m_held; m_valid = 1'b1; m_held_v = 1'b0; end
        end else if (xf) begin
            if (s) begin
                m_held = {m_pc + 30'd1, mem_f(m_pc)}; m_held_v = 1'b1;
            end else begin
                m_data = {m_pc + 30'd1, mem_f(m_pc)}; m_valid = 1'b1;
            end
            m_pc = m_pc + 30'd1;
        end else if (!s) begin
            m_data = 62'h0; m_valid = 1'b0;
        end
    endtask

    // Compare the DUT against the model, then drive the next cycle.
    task automatic cyc(input bit e, input bit r, input logic [29:0] rp,
                       input bit f, input bit s, input bit rd);
        @(negedge clk);
        chk("imem_req", {63'h0, bus.imem_req}, {63'h0, !m_held_v});
        if (!m_held_v) chk("imem_addr", {34'h0, bus.imem_addr}, {34'h0, m_pc});
        chk("id_data", {2'b00, id_data}, {2'b00, m_data});
        chk("id_valid", {63'h0, id_valid}, {63'h0, m_valid});
        chk("o_pc", {34'h0, pc_o}, {34'h0, m_pc});
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", {32'h0, perf_fetch}, {32'h0, m_fcnt});
        chk("perf_wait", {32'h0, perf_wait}, {32'h0, m_wcnt});
`endif
        drive_and_step(e, r, rp, f, s, rd);
    endtask

    task automatic check_reset_values();
        chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
        chk("rst_data", {2'b00, id_data}, 64'h0);
        chk("rst_valid", {63'h0, id_valid}, 64'h0);
        chk("rst_pc", {34'h0, pc_o}, 64'h0C00);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", {32'h0, perf_fetch}, 64'h0);
        chk("rst_perf_wait", {32'h0, perf_wait}, 64'h0);
`endif
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        drive_and_step(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0);

        // Zero-wait streaming from the reset vector.
        cyc(0, 0, 30'h0, 0, 0, 1); chk("lit_addr0", {34'h0, bus.imem_addr}, 64'h0C00);
        cyc(0, 0, 30'h0, 0, 0, 1); chk("lit_addr1", {34'h0, bus.imem_addr}, 64'h0C01);
        chk("lit_first", {2'b00, id_data}, {2'b00, 30'h0C01, mem_f(30'h0C00)});
        chk("lit_valid1", {63'h0, id_valid}, 64'h1);
        cyc(0, 0, 30'h0, 0, 0, 1); chk("lit_addr2", {34'h0, bus.imem_addr}, 64'h0C02);

        // Three stall cycles: one fetch lands in the hold buffer, then it is released.
        cyc(0, 0, 30'h0, 0, 1, 1);
        cyc(0, 0, 30'h0, 0, 1, 1); chk("lit_hold_req", {63'h0, bus.imem_req}, 64'h0);
        chk("lit_frozen", {2'b00, id_data}, {2'b00, 30'h0C03, mem_f(30'h0C02)});
        cyc(0, 0, 30'h0, 0, 1, 1);
        cyc(0, 0, 30'h0, 0, 0, 1);
        cyc(0, 0, 30'h0, 0, 0, 1);
        chk("lit_released", {2'b00, id_data}, {2'b00, 30'h0C04, mem_f(30'h0C03)});

        // Flush during a transfer at 0x0C05.
        cyc(0, 0, 30'h0, 1, 0, 1); chk("lit_flush_addr", {34'h0, bus.imem_addr}, 64'h0C05);
        cyc(0, 0, 30'h0, 0, 0, 0); chk("lit_after_flush", {34'h0, bus.imem_addr}, 64'h0C06);
        chk("lit_flush_valid", {63'h0, id_valid}, 64'h0);

        // Redirect while memory is busy: old address held, then target fetched.
        cyc(0, 1, 30'h0D00, 0, 0, 0);
        cyc(0, 0, 30'h0, 0, 0, 0); chk("lit_drop_addr", {34'h0, bus.imem_addr}, 64'h0C06);
        cyc(0, 0, 30'h0, 0, 0, 1);
        cyc(0, 0, 30'h0, 0, 0, 1); chk("lit_redir_addr", {34'h0, bus.imem_addr}, 64'h0D00);
        chk("lit_drop_valid", {63'h0, id_valid}, 64'h0);

        // Exception beats a same-cycle redirect.
        cyc(1, 1, 30'h0D00, 0, 0, 1);
        cyc(0, 0, 30'h0, 0, 0, 0); chk("lit_exc_addr", {34'h0, bus.imem_addr}, 64'h1060);
        chk("lit_exc_data", {2'b00, id_data}, 64'h0);

        // PC wrap at the top of the word space.
        cyc(0, 1, 30'h3FFF_FFFF, 0, 0, 1);
        cyc(0, 0, 30'h0, 0, 0, 1); chk("lit_top_addr", {34'h0, bus.imem_addr}, 64'h3FFF_FFFF);
        cyc(0, 0, 30'h0, 0, 0, 0); chk("lit_wrap_addr", {34'h0, bus.imem_addr}, 64'h0);
        chk("lit_wrap_data", {2'b00, id_data}, {2'b00, 30'h0, mem_f(30'h3FFF_FFFF)});

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [29:0] rp;
            rp = ($urandom_range(3, 0) == 0) ? (30'h3FFF_FFFE + 30'($urandom_range(1, 0)))
                                             : 30'($urandom);
            cyc($urandom_range(31, 0) == 0, $urandom_range(15, 0) == 0, rp,
                $urandom_range(15, 0) == 0, $urandom_range(3, 0) == 0,
                $urandom_range(2, 0) != 0);
        end

        // Asynchronous reset in the middle of a drop with stall asserted.
        cyc(0, 1, 30'h0D00, 0, 1, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values();
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_and_step(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 30'h0, 0, 0, 1); chk("lit_restart", {34'h0, bus.imem_addr}, 64'h0C00);
        cyc(0, 0, 30'h0, 0, 0, 1);
        cyc(0, 0, 30'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. Holds the word-addressed PC, fetches from instruction memory over a req/rdy handshake, and loads the IF/ID pipeline register (PC+1, instr) that feeds the decode stage.
- Accepts redirects (branch/jump NPC from decode, exception/ERET) and stall/flush from hazard control.
- Drops stale in-flight fetches and inserts bubbles (instr=0, sll $0 NOP).

Parameters:
- RESET_PC, 30'h0C00 (byte 0x0000_3000), word address loaded on reset.
- EXC_PC, 30'h1060 (byte 0x0000_4180), word address loaded on exception entry.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IF_STALL  in  1  decode cannot accept; hold the IF/ID register.
- IF_FLUSH  in  1  squash the IF/ID register contents (bubble).
- redirect_valid  in  1  decode resolved a taken branch/jump/ERET.
- redirect_pc  in  30  target word address [31:2].
- exc_valid  in  1  exception entry; target is EXC_PC.
- imem_req  out  1  fetch request.
- imem_addr  out  30  word address; stable while req=1 and rdy=0.
- imem_rdy  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction, valid when req&rdy.
- o_ID_DATA  out  62  {PCP1[31:2], instr[31:0]} to decode.
- o_ID_valid  out  1  o_ID_DATA holds a real instruction.
- o_pc  out  30  current fetch PC (debug/CP0 EPC source).

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=FETCH, o_ID_DATA=0, o_ID_valid=0, hold buffer empty, drop flag 0, imem_req=0 while rst asserted. The first request is issued in the first cycle after rst deasserts.
- States: FETCH, HOLD, DROP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a transfer (req&rdy) with IF_STALL=0: o_ID_DATA<={pc+1, imem_rdata}, o_ID_valid<=1, pc<=pc+1.
  - On a transfer with IF_STALL=1: capture {pc+1, rdata} into the hold buffer, pc<=pc+1, go to HOLD.
  - No transfer with IF_STALL=0: o_ID_valid<=0, o_ID_DATA<=0.
  - Zero-wait memory gives 1 instr/cycle.
- HOLD:
  - imem_req=0.
  - When IF_STALL=0: o_ID_DATA<=buffer, o_ID_valid<=1, then go to FETCH.
- DROP:
  - imem_req=1 with the old address held (address stability rule).
  - On rdy: discard the data, pc<=saved target, go to FETCH. The target is saved in pc_next_r at redirect time.
- IF_STALL=1 (no redirect): o_ID_DATA and o_ID_valid hold their values.
- Redirect/exception priority: exc_valid > redirect_valid > IF_FLUSH > IF_STALL. A redirect or exception takes effect regardless of stall.
  - Target T = exc_valid ? EXC_PC : redirect_pc.
  - o_ID_DATA<=0, o_ID_valid<=0, hold buffer cleared.
  - If state=FETCH with req=1 and rdy=0 that cycle: save T, go to DROP.
  - If rdy=1 that same cycle: the fetched data is discarded, pc<=T, stay/go to FETCH.
  - From HOLD: pc<=T, go to FETCH.
  - From DROP: update the saved target to T (latest redirect wins).
- IF_FLUSH alone: o_ID_DATA<=0, o_ID_valid<=0, hold buffer cleared. pc unaffected. A same-cycle transfer still advances pc, and its data is dropped.
- Arithmetic: pc+1 is a 30-bit wrap (3FFF_FFFF+1 -> 0). No alignment checks; word addressing makes misalignment impossible.
- Decode-stage delay slot is not modelled. The instruction after a branch is squashed by redirect.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (accepted transfers not dropped) and perf_wait_cnt[31:0] (cycles with req=1, rdy=0). Both reset to 0 on rst, wrap at 2^32, and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds the state enum (FETCH=2'd0, HOLD=2'd1, DROP=2'd2), the IF_DATA_W=62 and PC_W=30 constants, and the NOP=32'h0 constant.
- One natural sub-module: if_hold_buf (one-entry 62-bit buffer with load/clear/valid). Everything else lives in if_stage.

Test Plan:
- Reset, rdy tied 1, imem returns addr-derived data -> after rst: imem_addr 0x0C00, 0x0C01, 0x0C02 on successive cycles; o_ID_DATA={0x0C01, data(0x0C00)} one cycle after the first transfer; o_ID_valid=1 continuous.
- IF_STALL=1 for 3 cycles mid-stream -> o_ID_DATA frozen; exactly one extra fetch buffered (state HOLD, req=0); after release, the buffered instr appears next cycle, no loss or duplicate.
- redirect_valid=1, redirect_pc=0x0D00 while imem_rdy=0 for 2 cycles -> imem_addr holds the old value; returned data dropped (o_ID_valid=0); next request addr=0x0D00.
- exc_valid and redirect_valid in the same cycle (redirect_pc=0x0D00) -> next fetch at EXC_PC 0x1060; o_ID_DATA=0, valid=0.
- IF_FLUSH=1 during a transfer at pc 0x0C05 -> o_ID_valid=0, o_ID_DATA=0; next fetch at 0x0C06.
- rst asserted mid-DROP with stall active -> all outputs at reset values immediately (async); fetch restarts at 0x0C00. With IF_PERF_CNT_EN, both counters read 0.
